// File: rtl/pwm_cfg_pkg.sv
// rtl/pwm_cfg_pkg.sv - shared types and constants for the PWM configuration controller
package pwm_cfg_pkg;

  // Default width of period / on-time counts.
  localparam int unsigned PWM_CNT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_VALIDATE = 2'd1,
    ST_WRITE    = 2'd2,
    ST_ACK      = 2'd3
  } pwm_cfg_state_e;

  typedef struct packed {
    logic [PWM_CNT_W-1:0] period;
    logic [PWM_CNT_W-1:0] on_time;
    logic                 enable;
  } pwm_cfg_t;

  // Write rejection reasons, highest priority first: bad channel, zero period, on > period.
  localparam logic [1:0] ERR_NONE         = 2'd0;
  localparam logic [1:0] ERR_ON_GT_PERIOD = 2'd1;
  localparam logic [1:0] ERR_ZERO_PERIOD  = 2'd2;
  localparam logic [1:0] ERR_BAD_CH       = 2'd3;

endpackage

// File: rtl/pwm_cfg_channel.sv
// rtl/pwm_cfg_channel.sv - one channel's shadow/active/pending/enable registers and commit logic
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   wr_stb_i          one-cycle write strobe for this channel (FSM in WRITE, channel selected)
//   period_i/on_i/en_i latched write values
//   reload_i          period-boundary pulse from this channel's PWM FSM
//   period_o/on_o     active reload values
//   enable_o          run enable to the PWM FSM
//   pending_o         shadow holds an uncommitted update
//   rd_period_o/rd_on_o  (PWM_CFG_READBACK_EN only) shadow if pending, else active
module pwm_cfg_channel #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_stb_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] on_i,
  input  logic             en_i,
  input  logic             reload_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] on_o,
  output logic             enable_o,
`ifdef PWM_CFG_READBACK_EN
  output logic [CNT_W-1:0] rd_period_o,
  output logic [CNT_W-1:0] rd_on_o,
`endif
  output logic             pending_o
);

  logic [CNT_W-1:0] act_period_q, act_period_d, act_on_q, act_on_d;
  logic [CNT_W-1:0] sh_period_q, sh_period_d, sh_on_q, sh_on_d;
  logic             en_q, en_d, pend_q, pend_d;

  always_comb begin
    act_period_d = act_period_q;
    act_on_d     = act_on_q;
    sh_period_d  = sh_period_q;
    sh_on_d      = sh_on_q;
    en_d         = en_q;
    pend_d       = pend_q;
    if (wr_stb_i) begin
      if (!en_q || !en_i) begin
        // Stopped channel, or a write that stops it: no running period to protect.
        act_period_d = period_i;
        act_on_d     = on_i;
        en_d         = en_i;
        pend_d       = 1'b0;
      end else begin
        sh_period_d = period_i;
        sh_on_d     = on_i;
        if (reload_i) begin
          // Boundary on the same edge: the fresh write is what commits.
          act_period_d = period_i;
          act_on_d     = on_i;
          pend_d       = 1'b0;
        end else begin
          pend_d = 1'b1;
        end
      end
    end else if (reload_i && pend_q) begin
      act_period_d = sh_period_q;
      act_on_d     = sh_on_q;
      pend_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_period_q <= '0;
      act_on_q     <= '0;
      sh_period_q  <= '0;
      sh_on_q      <= '0;
      en_q         <= 1'b0;
      pend_q       <= 1'b0;
    end else begin
      act_period_q <= act_period_d;
      act_on_q     <= act_on_d;
      sh_period_q  <= sh_period_d;
      sh_on_q      <= sh_on_d;
      en_q         <= en_d;
      pend_q       <= pend_d;
    end
  end

  assign period_o  = act_period_q;
  assign on_o      = act_on_q;
  assign enable_o  = en_q;
  assign pending_o = pend_q;
`ifdef PWM_CFG_READBACK_EN
  assign rd_period_o = pend_q ? sh_period_q : act_period_q;
  assign rd_on_o     = pend_q ? sh_on_q : act_on_q;
`endif

endmodule

// File: rtl/pwm_cfg_ctrl.sv
// rtl/pwm_cfg_ctrl.sv - PWM bank configuration controller: write handshake FSM and channel decode
//
// Optional feature macro: PWM_CFG_READBACK_EN (adds registered readback ports).
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   wr_req/wr_ack/wr_err write handshake; ack is a one-cycle pulse, err valid with ack
//   wr_ch/wr_period/wr_on_time/wr_enable  write payload, latched in IDLE
//   reload_times        per-channel period-boundary pulses
//   T_period_value/T_on_value  active reload values, channel 0 in LSBs
//   pwm_enable/pending  per-channel run enable and uncommitted-update flags
//   rd_ch/rd_period/rd_on_time/rd_pending  readback (PWM_CFG_READBACK_EN only)
module pwm_cfg_ctrl
  import pwm_cfg_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int CNT_W  = PWM_CNT_W,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_req,
  input  logic [CH_W-1:0]         wr_ch,
  input  logic [CNT_W-1:0]        wr_period,
  input  logic [CNT_W-1:0]        wr_on_time,
  input  logic                    wr_enable,
  output logic                    wr_ack,
  output logic                    wr_err,
  input  logic [NUM_CH-1:0]       reload_times,
  output logic [NUM_CH*CNT_W-1:0] T_period_value,
  output logic [NUM_CH*CNT_W-1:0] T_on_value,
  output logic [NUM_CH-1:0]       pwm_enable,
`ifdef PWM_CFG_READBACK_EN
  input  logic [CH_W-1:0]         rd_ch,
  output logic [CNT_W-1:0]        rd_period,
  output logic [CNT_W-1:0]        rd_on_time,
  output logic                    rd_pending,
`endif
  output logic [NUM_CH-1:0]       pending
);

  // Channel indices are compared one bit wider so a non-power-of-two bank can flag bad channels.
  localparam logic [CH_W:0] NUM_CH_EXT = (CH_W+1)'(NUM_CH);

  pwm_cfg_state_e   state_q, state_d;
  logic             wr_ack_q, wr_ack_d, wr_err_q, wr_err_d;
  logic [CH_W-1:0]  lat_ch_q;
  logic [CNT_W-1:0] lat_period_q, lat_on_q;
  logic             lat_en_q;
  logic [1:0]       err_code;

  always_comb begin
    err_code = ERR_NONE;
    if ({1'b0, lat_ch_q} >= NUM_CH_EXT)  err_code = ERR_BAD_CH;
    else if (lat_period_q == '0)         err_code = ERR_ZERO_PERIOD;
    else if (lat_on_q > lat_period_q)    err_code = ERR_ON_GT_PERIOD;
  end

  always_comb begin
    state_d  = state_q;
    wr_err_d = 1'b0;
    case (state_q)
      ST_IDLE:     if (wr_req) state_d = ST_VALIDATE;
      ST_VALIDATE: begin
        if (err_code != ERR_NONE) begin
          state_d  = ST_ACK;
          wr_err_d = 1'b1;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE:    state_d = ST_ACK;
      ST_ACK:      state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    // Registered ack lines up exactly with the ACK state.
    wr_ack_d = (state_d == ST_ACK);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      wr_ack_q     <= 1'b0;
      wr_err_q     <= 1'b0;
      lat_ch_q     <= '0;
      lat_period_q <= '0;
      lat_on_q     <= '0;
      lat_en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ack_q <= wr_ack_d;
      wr_err_q <= wr_err_d;
      if (state_q == ST_IDLE && wr_req) begin
        lat_ch_q     <= wr_ch;
        lat_period_q <= wr_period;
        lat_on_q     <= wr_on_time;
        lat_en_q     <= wr_enable;
      end
    end
  end

  assign wr_ack = wr_ack_q;
  assign wr_err = wr_err_q;

`ifdef PWM_CFG_READBACK_EN
  logic [CNT_W-1:0] view_period [NUM_CH];
  logic [CNT_W-1:0] view_on     [NUM_CH];
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pwm_cfg_channel #(.CNT_W(CNT_W)) u_ch (
      .clk        (clk),
      .reset      (reset),
      .wr_stb_i   ((state_q == ST_WRITE) && (lat_ch_q == CH_W'(c))),
      .period_i   (lat_period_q),
      .on_i       (lat_on_q),
      .en_i       (lat_en_q),
      .reload_i   (reload_times[c]),
      .period_o   (T_period_value[c*CNT_W +: CNT_W]),
      .on_o       (T_on_value[c*CNT_W +: CNT_W]),
      .enable_o   (pwm_enable[c]),
`ifdef PWM_CFG_READBACK_EN
      .rd_period_o(view_period[c]),
      .rd_on_o    (view_on[c]),
`endif
      .pending_o  (pending[c])
    );
  end

`ifdef PWM_CFG_READBACK_EN
  logic [CNT_W-1:0] rd_period_q, rd_on_q;
  logic             rd_pending_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_period_q  <= '0;
      rd_on_q      <= '0;
      rd_pending_q <= 1'b0;
    end else if ({1'b0, rd_ch} < NUM_CH_EXT) begin
      rd_period_q  <= view_period[rd_ch];
      rd_on_q      <= view_on[rd_ch];
      rd_pending_q <= pending[rd_ch];
    end else begin
      rd_period_q  <= '0;
      rd_on_q      <= '0;
      rd_pending_q <= 1'b0;
    end
  end

  assign rd_period  = rd_period_q;
  assign rd_on_time = rd_on_q;
  assign rd_pending = rd_pending_q;
`endif

endmodule

// File: tb/tb_pwm_cfg_ctrl.sv
// tb/tb_pwm_cfg_ctrl.sv - self-checking bench for pwm_cfg_ctrl against a transaction-level model
module tb_pwm_cfg_ctrl;
  import pwm_cfg_pkg::*;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    wr_req = 1'b0;
  logic [1:0]              wr_ch = '0;
  logic [CNT_W-1:0]        wr_period = '0;
  logic [CNT_W-1:0]        wr_on_time = '0;
  logic                    wr_enable = 1'b0;
  logic                    wr_ack, wr_err;
  logic [NUM_CH-1:0]       reload_times = '0;
  logic [NUM_CH*CNT_W-1:0] T_period_value, T_on_value;
  logic [NUM_CH-1:0]       pwm_enable, pending;
`ifdef PWM_CFG_READBACK_EN
  logic [1:0]              rd_ch = '0;
  logic [CNT_W-1:0]        rd_period, rd_on_time;
  logic                    rd_pending;
`endif

  pwm_cfg_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_req        (wr_req),
    .wr_ch         (wr_ch),
    .wr_period     (wr_period),
    .wr_on_time    (wr_on_time),
    .wr_enable     (wr_enable),
    .wr_ack        (wr_ack),
    .wr_err        (wr_err),
    .reload_times  (reload_times),
    .T_period_value(T_period_value),
    .T_on_value    (T_on_value),
    .pwm_enable    (pwm_enable),
`ifdef PWM_CFG_READBACK_EN
    .rd_ch         (rd_ch),
    .rd_period     (rd_period),
    .rd_on_time    (rd_on_time),
    .rd_pending    (rd_pending),
`endif
    .pending       (pending)
  );

  always #5 clk = ~clk;

  // Reference model: what each channel's PWM is running now, and what is queued behind it.
  pwm_cfg_t m_act [NUM_CH];
  pwm_cfg_t m_sh  [NUM_CH];
  bit       m_pend[NUM_CH];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [NUM_CH*CNT_W-1:0] got,
                       input logic [NUM_CH*CNT_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_act[c]  = '0;
      m_sh[c]   = '0;
      m_pend[c] = 1'b0;
    end
  endfunction

  // A running channel that stays enabled must not change mid-period: queue it.
  function automatic void model_write(input int ch, input logic [CNT_W-1:0] p,
                                      input logic [CNT_W-1:0] o, input bit e);
    pwm_cfg_t v;
    v.period  = p;
    v.on_time = o;
    v.enable  = e;
    if (m_act[ch].enable && e) begin
      m_sh[ch]   = v;
      m_pend[ch] = 1'b1;
    end else begin
      m_act[ch]  = v;
      m_pend[ch] = 1'b0;
    end
  endfunction

  function automatic void model_boundary(input logic [NUM_CH-1:0] mask);
    for (int c = 0; c < NUM_CH; c++)
      if (mask[c] && m_pend[c]) begin
        m_act[c]  = m_sh[c];
        m_pend[c] = 1'b0;
      end
  endfunction

  task automatic check_outputs(input string tag);
    logic [NUM_CH*CNT_W-1:0] ep, eo;
    logic [NUM_CH-1:0]       een, epd;
    for (int c = 0; c < NUM_CH; c++) begin
      ep[c*CNT_W +: CNT_W] = m_act[c].period;
      eo[c*CNT_W +: CNT_W] = m_act[c].on_time;
      een[c] = m_act[c].enable;
      epd[c] = m_pend[c];
    end
    check({tag, "/period"},  T_period_value, ep);
    check({tag, "/on"},      T_on_value, eo);
    check({tag, "/enable"},  {124'd0, pwm_enable}, {124'd0, een});
    check({tag, "/pending"}, {124'd0, pending}, {124'd0, epd});
  endtask

  // One full handshake; rel_mask is raised so it lands on the WRITE edge of a valid write.
  task automatic do_write(input string tag, input int ch, input logic [CNT_W-1:0] p,
                          input logic [CNT_W-1:0] o, input bit e,
                          input logic [NUM_CH-1:0] rel_mask);
    bit exp_err;
    int lat;
    exp_err = (o > p) || (p == 0);
    lat = 0;
    @(negedge clk);
    wr_req = 1'b1; wr_ch = 2'(ch); wr_period = p; wr_on_time = o; wr_enable = e;
    for (int cyc = 1; cyc <= 8 && lat == 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        wr_period = $urandom; wr_on_time = $urandom; wr_enable = 1'($urandom);
      end
      if (wr_ack) begin
        lat = cyc;
        reload_times = '0;
      end else if (cyc == 2) begin
        reload_times = rel_mask;
      end else begin
        reload_times = '0;
      end
    end
    reload_times = '0;
    if (lat == 0) begin
      check({tag, "/ack_timeout"}, 0, 1);
    end else begin
      check({tag, "/ack_latency"}, lat, exp_err ? 2 : 3);
      check({tag, "/wr_err"}, {127'd0, wr_err}, {127'd0, exp_err});
      if (!exp_err) begin
        model_write(ch, p, o, e);
        model_boundary(rel_mask);
      end
      check_outputs(tag);
    end
    wr_req = 1'b0;
    @(negedge clk);
    check({tag, "/ack_pulse"}, {127'd0, wr_ack}, 0);
  endtask

  task automatic pulse_reload(input string tag, input logic [NUM_CH-1:0] mask);
    @(negedge clk);
    reload_times = mask;
    @(negedge clk);
    reload_times = '0;
    model_boundary(mask);
    check_outputs(tag);
  endtask

  initial begin
    bit saw_ack;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_outputs("reset");
    check("reset/wr_ack", {127'd0, wr_ack}, 0);
    check("reset/wr_err", {127'd0, wr_err}, 0);

    // Disabled channel takes values at once.
    do_write("t1", 0, 100, 25, 1'b1, '0);
    // Running channel queues, then commits on its boundary.
    do_write("t2_wr", 0, 200, 50, 1'b1, '0);
    pulse_reload("t2_idle_other", 4'b0010);
    pulse_reload("t2_commit", 4'b0001);
    // Rejected writes.
    do_write("t3_on_gt", 1, 50, 60, 1'b1, '0);
    do_write("t3_zero", 1, 0, 0, 1'b1, '0);
    do_write("t3_on_eq", 1, 40, 40, 1'b0, '0);
    // Disable while pending.
    do_write("t4_a", 2, 100, 30, 1'b1, '0);
    do_write("t4_b", 2, 90, 40, 1'b1, '0);
    do_write("t4_dis", 2, 80, 20, 1'b0, '0);
    // Last write wins; same-edge write and boundary.
    do_write("t5_a", 3, 50, 5, 1'b1, '0);
    do_write("t5_b", 3, 50, 10, 1'b1, '0);
    do_write("t5_c", 3, 50, 20, 1'b1, '0);
    pulse_reload("t5_commit", 4'b1000);
    do_write("t5_same", 3, 60, 30, 1'b1, 4'b1000);

    // Reset during VALIDATE drops the write.
    @(negedge clk);
    wr_req = 1'b1; wr_ch = 2'd1; wr_period = 70; wr_on_time = 7; wr_enable = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wr_req = 1'b0;
    model_reset();
    saw_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      saw_ack = saw_ack | wr_ack;
    end
    check_outputs("t6_reset");
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      saw_ack = saw_ack | wr_ack;
    end
    check("t6_no_ack", {127'd0, saw_ack}, 0);
    do_write("t6_after", 1, 70, 7, 1'b1, '0);

    // Random mix of writes and boundaries.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0)
        pulse_reload("rnd_rel", 4'($urandom_range(0, 15)));
      else
        do_write("rnd_wr", $urandom_range(0, NUM_CH-1), 32'($urandom_range(0, 300)),
                 32'($urandom_range(0, 320)), 1'($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
